oled_bounce_gen: RTL and testbench
==================================

# oled_bounce_gen

Upstream pixel source for the ST7789 SPI video stage. It consumes the pixel coordinate `x`/`y` that the video stage scans out and returns a registered RGB565 `color`. The picture is a checkerboard background with a square box that moves diagonally and bounces off the screen edges. Box position updates once per frame; a frame boundary is detected from the `y` scan wrapping.

## Interface
Parameters:
- `C_width`, 128: visible columns; x range 0..C_width-1
- `C_height`, 240: visible rows; y range 0..C_height-1
- `C_box`, 16: box edge length in pixels; must be less than C_width and less than C_height
- `C_speed`, 1: pixels moved per frame on each axis; must be at least 1

Ports:
- `clk`  in  1: system clock (25 MHz)
- `reset`  in  1: synchronous, active-high reset
- `x`  in  7: current scan column from the video stage
- `y`  in  8: current scan row from the video stage
- `color`  out  16: RGB565 pixel colour, registered
- `frame_tick`  out  1: one-cycle pulse when a new frame begins
- `bounce_count`  out  8: number of bounce events, wraps at 255→0

## Operation
- **Box state, per axis:** position `p` in 0..(C_size-C_box) and a direction bit. Direction 0 means increasing.
- **Reset values:** bx=0, by=0, both directions 0, `color`=0, `frame_tick`=0, `bounce_count`=0, y_prev=0, palette index=0.
- **Frame detect:** at an edge where y_prev==C_height-1 and sampled y==0:
  - `frame_tick` is set for one cycle.
  - Both axes are updated.
  - y_prev is loaded from `y` every cycle.
  - If `y` is held at 0 for many clocks, only one tick is produced.
- **Axis update, increasing direction:**
  - If p+C_speed ≥ max, then p←max and the direction flips.
  - Otherwise p←p+C_speed.
- **Axis update, decreasing direction:**
  - If p ≤ C_speed, then p←0 and the direction flips.
  - Otherwise p←p−C_speed.
- **Arithmetic:** done at 9 bits unsigned, so the sum cannot overflow.
- **Bounce event:** any axis flips on a tick. If both axes flip on the same tick (corner), it counts as one event. `bounce_count` increments by 1 per event.
- **Pixel colour priority:**
  - Box first: bx ≤ x < bx+C_box AND by ≤ y < by+C_box gives the box colour.
  - Else, if x[3]^y[3], the colour is 16'h07E0 (green).
  - Else, the colour is 16'hF800 (red).
- **Out-of-range input:** coordinates with x ≥ C_width or y ≥ C_height still produce a colour from the same rule. No error is flagged.

## Timing
- `color` latency is one clock from `x`/`y`: `color` at cycle n+1 reflects x,y sampled at edge n.
- The video stage holds each coordinate for 16 or more clocks per pixel, so a one-clock latency is always met.
- On a tick edge, `color` is computed from the pre-update position. The new position takes effect from the following edge.
- `frame_tick` and the updated `bounce_count` become visible together in the cycle after the detecting edge.
- Reset during a frame:
  - All state clears.
  - The first tick after reset requires y==C_height-1 to be observed and then y==0.

## Configuration
- `OLED_BOUNCE_COLOR_CYCLE_EN` defined:
  - The box colour comes from an 8-entry palette indexed by a 3-bit counter.
  - The counter increments on each bounce event and wraps 7→0.
  - Entry 0 is 16'hFFFF.
- Not defined:
  - The box colour is fixed at 16'hFFFF.
  - No palette or index register is built.

## Structure
- **Package `oled_bounce_pkg`:**
  - RGB565 colour typedef.
  - Constants for white, red and green.
  - The 8-entry palette constant: FFFF, F800, 07E0, 001F, FFE0, F81F, 07FF, 8410.
- **Sub-module `bounce_axis`:**
  - Parameters: size, box, speed.
  - Inputs: clk, reset, tick.
  - Outputs: pos, bounced.
  - Instantiated twice, once for x and once for y. The top level ORs the two `bounced` outputs to form the bounce event.

## Test plan
1. **Reset output:** hold reset 3 clocks with x=5,y=5, then release → `color`=0 and `frame_tick`=0 throughout reset. With x=5,y=5 applied after release, `color`=FFFF at the next edge.
2. **Pixel colours at reset position:**
   - x=0,y=0 → FFFF.
   - x=8,y=20 → 07E0.
   - x=16,y=0 → F800.
   - x=15,y=15 → FFFF.
3. **Frame tick:** drive y=239, then y=0 held for 10 clocks → exactly one `frame_tick` pulse, and bx=by=1 afterwards.
4. **Right-edge bounce:** defaults, 112 frames → bx=112, `bounce_count`=1, x direction flipped. Frame 113 gives bx=111. Frame 224 gives by=224 and `bounce_count`=2.
5. **Corner:** C_height=128, 112 frames → both axes flip on the same tick, and `bounce_count`=1 (not 2).
6. **Colour cycling:** with `OLED_BOUNCE_COLOR_CYCLE_EN` defined, after the first bounce the box pixel is F800. Without the macro it stays FFFF. Reset mid-run returns the box colour to FFFF.

Source files
------------

// File: rtl/oled_bounce_pkg.sv
// Shared colour types and constants for the bouncing-box pixel source.
// The 8-entry palette is used only when OLED_BOUNCE_COLOR_CYCLE_EN is defined.
package oled_bounce_pkg;

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t C_WHITE = 16'hFFFF;
   localparam rgb565_t C_RED   = 16'hF800;
   localparam rgb565_t C_GREEN = 16'h07E0;

   // Entry 0 sits in the low 16 bits so C_PALETTE[idx] selects entry idx.
   localparam logic [7:0][15:0] C_PALETTE = {
      16'h8410, 16'h07FF, 16'hF81F, 16'hFFE0,
      16'h001F, 16'h07E0, 16'hF800, 16'hFFFF
   };

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position plus travel direction, stepped once per frame tick.
// bounced is combinational and asserts on the tick that reverses the direction.
module bounce_axis #(
   parameter int C_size  = 128,
   parameter int C_box   = 16,
   parameter int C_speed = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   output logic [8:0] pos,
   output logic       bounced
);

   localparam logic [8:0] C_MAX  = 9'(C_size - C_box);
   localparam logic [8:0] C_STEP = 9'(C_speed);

   logic [8:0] pos_q, pos_d;
   logic       dir_q, dir_d;

   always_comb begin
      pos_d   = pos_q;
      dir_d   = dir_q;
      bounced = 1'b0;
      if (tick) begin
         if (!dir_q) begin
            if (pos_q + C_STEP >= C_MAX) begin
               pos_d   = C_MAX;
               dir_d   = 1'b1;
               bounced = 1'b1;
            end else begin
               pos_d = pos_q + C_STEP;
            end
         end else begin
            // Clamp at zero rather than letting the subtraction wrap.
            if (pos_q <= C_STEP) begin
               pos_d   = 9'd0;
               dir_d   = 1'b0;
               bounced = 1'b1;
            end else begin
               pos_d = pos_q - C_STEP;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q <= 9'd0;
         dir_q <= 1'b0;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos = pos_q;

endmodule

// File: rtl/oled_bounce_gen.sv
// Checkerboard background with a diagonally bouncing box, one registered RGB565 pixel per x/y.
// Optional OLED_BOUNCE_COLOR_CYCLE_EN steps the box colour through a palette on each bounce.
module oled_bounce_gen
   import oled_bounce_pkg::*;
#(
   parameter int C_width  = 128,
   parameter int C_height = 240,
   parameter int C_box    = 16,
   parameter int C_speed  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] color,
   output logic        frame_tick,
   output logic [7:0]  bounce_count
);

   localparam logic [7:0] C_LAST_ROW = 8'(C_height - 1);
   localparam logic [8:0] C_BOX9     = 9'(C_box);

   logic [7:0] y_prev_q, y_prev_d;
   logic       frame_tick_q, frame_tick_d;
   logic [7:0] bounce_count_q, bounce_count_d;
   rgb565_t    color_q, color_d;
   logic       tick;
   logic [8:0] bx, by;
   logic       bx_bounced, by_bounced, bounce_evt;
   logic [8:0] x9, y9;
   logic       in_box;
   rgb565_t    box_color;

   assign tick       = (y_prev_q == C_LAST_ROW) && (y == 8'd0);
   assign bounce_evt = bx_bounced | by_bounced;

   bounce_axis #(.C_size(C_width), .C_box(C_box), .C_speed(C_speed)) u_axis_x (
      .clk(clk), .reset(reset), .tick(tick), .pos(bx), .bounced(bx_bounced)
   );

   bounce_axis #(.C_size(C_height), .C_box(C_box), .C_speed(C_speed)) u_axis_y (
      .clk(clk), .reset(reset), .tick(tick), .pos(by), .bounced(by_bounced)
   );

`ifdef OLED_BOUNCE_COLOR_CYCLE_EN
   logic [2:0] pal_idx_q, pal_idx_d;

   assign pal_idx_d = bounce_evt ? pal_idx_q + 3'd1 : pal_idx_q;
   assign box_color = C_PALETTE[pal_idx_q];

   always_ff @(posedge clk) begin
      if (reset) pal_idx_q <= 3'd0;
      else       pal_idx_q <= pal_idx_d;
   end
`else
   assign box_color = C_WHITE;
`endif

   assign x9     = {2'b00, x};
   assign y9     = {1'b0, y};
   assign in_box = (x9 >= bx) && (x9 < bx + C_BOX9) && (y9 >= by) && (y9 < by + C_BOX9);

   // Colour uses the position registers as they stand, so a tick edge still paints the old box.
   always_comb begin
      y_prev_d       = y;
      frame_tick_d   = tick;
      bounce_count_d = bounce_evt ? bounce_count_q + 8'd1 : bounce_count_q;
      color_d        = C_RED;
      if (in_box)          color_d = box_color;
      else if (x[3] ^ y[3]) color_d = C_GREEN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y_prev_q       <= 8'd0;
         frame_tick_q   <= 1'b0;
         bounce_count_q <= 8'd0;
         color_q        <= 16'h0000;
      end else begin
         y_prev_q       <= y_prev_d;
         frame_tick_q   <= frame_tick_d;
         bounce_count_q <= bounce_count_d;
         color_q        <= color_d;
      end
   end

   assign color        = color_q;
   assign frame_tick   = frame_tick_q;
   assign bounce_count = bounce_count_q;

endmodule

// File: tb/tb_oled_bounce_gen.sv
// Bench for oled_bounce_gen: default geometry plus a 128x128 instance for the corner case.
// Box motion is modelled as a triangle wave of the frame number (speed 1).
module tb_oled_bounce_gen;

   localparam int MXA = 112;   // 128 - 16
   localparam int MYA = 224;   // 240 - 16
   localparam int MB  = 112;   // 128 - 16 on both axes

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  x;
   logic [7:0]  y_a, y_b;
   logic [15:0] color_a, color_b;
   logic        tick_a, tick_b;
   logic [7:0]  bc_a, bc_b;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [15:0] exp_q[$];
   int          frames_a = 0;
   int          frames_b = 0;
   logic [7:0]  events_a = 8'd0;
   logic [7:0]  events_b = 8'd0;
   logic [7:0]  last_y_a = 8'd0;
   logic [15:0] pal [8] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F,
                            16'hFFE0, 16'hF81F, 16'h07FF, 16'h8410};

   always #20 clk = ~clk;

   oled_bounce_gen dut_a (
      .clk(clk), .reset(reset), .x(x), .y(y_a),
      .color(color_a), .frame_tick(tick_a), .bounce_count(bc_a)
   );

   oled_bounce_gen #(.C_height(128)) dut_b (
      .clk(clk), .reset(reset), .x(x), .y(y_b),
      .color(color_b), .frame_tick(tick_b), .bounce_count(bc_b)
   );

   // ---------------- reference model ----------------
   function automatic int tri_pos(input int n, input int m);
      int r;
      r = n % (2 * m);
      return (r <= m) ? r : 2 * m - r;
   endfunction

   function automatic logic [15:0] box_col(input logic [7:0] ev);
`ifdef OLED_BOUNCE_COLOR_CYCLE_EN
      return pal[int'(ev) % 8];
`else
      return (ev == ev) ? 16'hFFFF : 16'hFFFF;
`endif
   endfunction

   function automatic logic [15:0] ref_color(input int px, input int py, input int bx,
                                             input int by, input logic [7:0] ev);
      if (px >= bx && px < bx + 16 && py >= by && py < by + 16) return box_col(ev);
      if ((((px / 8) ^ (py / 8)) & 1) == 1) return 16'h07E0;
      return 16'hF800;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe_a(input int px, input int py);
      if (last_y_a == 8'd239 && py == 0) py = 1;   // never fake a frame boundary
      x        = 7'(px);
      y_a      = 8'(py);
      last_y_a = 8'(py);
      exp_q.push_back(ref_color(px, py, tri_pos(frames_a, MXA), tri_pos(frames_a, MYA), events_a));
      step();
      check("color_a", color_a, exp_q.pop_front());
      check("tick_a_idle", {15'b0, tick_a}, 16'd0);
   endtask

   task automatic probe_b(input int px, input int py);
      x   = 7'(px);
      y_b = 8'(py);
      exp_q.push_back(ref_color(px, py, tri_pos(frames_b, MB), tri_pos(frames_b, MB), events_b));
      step();
      check("color_b", color_b, exp_q.pop_front());
      y_b = 8'd0;
      step();
   endtask

   task automatic frame_a(input int hold);
      int ticks;
      y_a = 8'd239;
      step();
      check("tick_a_pre", {15'b0, tick_a}, 16'd0);
      y_a = 8'd0;
      step();
      ticks = tick_a ? 1 : 0;
      frames_a++;
      if (frames_a % MXA == 0 || frames_a % MYA == 0) events_a++;
      for (int i = 1; i < hold; i++) begin
         step();
         if (tick_a) ticks++;
      end
      check("tick_a_count", 16'(ticks), 16'd1);
      check("bounce_count_a", {8'b0, bc_a}, {8'b0, events_a});
      last_y_a = 8'd0;
   endtask

   task automatic frame_b();
      y_b = 8'd127;
      step();
      y_b = 8'd0;
      step();
      frames_b++;
      if (frames_b % MB == 0) events_b++;
      check("tick_b", {15'b0, tick_b}, 16'd1);
      check("bounce_count_b", {8'b0, bc_b}, {8'b0, events_b});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bxm, bym, px, py;
      reset = 1'b1;
      x     = 7'd5;
      y_a   = 8'd5;
      y_b   = 8'd0;
      last_y_a = 8'd5;

      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_color_a", color_a, 16'h0000);
         check("reset_tick_a", {15'b0, tick_a}, 16'd0);
      end
      reset = 1'b0;
      step();
      check("post_reset_color", color_a, 16'hFFFF);
      check("post_reset_bc", {8'b0, bc_a}, 16'd0);

      probe_a(0, 0);
      probe_a(8, 20);
      probe_a(16, 0);
      probe_a(15, 15);

      frame_a(10);
      probe_a(1, 1);
      probe_a(0, 1);

      while (frames_a < 230) begin
         frame_a(1);
         bxm = tri_pos(frames_a, MXA);
         bym = tri_pos(frames_a, MYA);
         px  = bxm + int'($urandom_range(0, 17)) - 1;
         py  = bym + int'($urandom_range(0, 17)) - 1;
         if (px < 0) px = 0;
         if (px > 127) px = 127;
         if (py < 0) py = 0;
         if (py > 238) py = 238;
         probe_a(px, py);
         probe_a(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
      end

      for (int i = 0; i < MB; i++) frame_b();
      probe_b(112, 112);
      probe_b(111, 111);
      frame_b();
      probe_b(111, 111);
      probe_b(127, 127);

      reset = 1'b1;
      y_a   = 8'd5;
      x     = 7'd5;
      step();
      step();
      reset    = 1'b0;
      frames_a = 0;
      events_a = 8'd0;
      last_y_a = 8'd5;
      probe_a(5, 5);
      check("reset_mid_bc", {8'b0, bc_a}, 16'd0);
      frame_a(1);
      probe_a(16, 16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
